// File: rtl/gppcu_instr_dispatcher.sv
// gppcu_instr_dispatcher: fetches a block of instruction words from a synchronous RAM through a
// 2-entry prefetch FIFO and issues them on a VALID/READY port. After the last handshake it waits
// for the core to go idle and pulses oDONE.
// Optional abort input: define GPPCU_DISPATCH_ABORT_EN to add iABORT.
module gppcu_instr_dispatcher #(
  parameter int unsigned DBW  = 32,
  parameter int unsigned IABW = 10
) (
  input  logic            iACLK,
  input  logic            inRST,
  input  logic            iSTART,
  input  logic [IABW-1:0] iBASE_ADDR,
  input  logic [IABW:0]   iCOUNT,
  output logic            oBUSY,
  output logic            oDONE,
  output logic [IABW-1:0] oIMEM_ADDR,
  output logic            oIMEM_RD,
  input  logic [DBW-1:0]  iIMEM_RDATA,
  output logic [DBW-1:0]  oINSTR,
  output logic            oINSTR_VALID,
  input  logic            iINSTR_READY,
  input  logic            iCORE_IDLING,
`ifdef GPPCU_DISPATCH_ABORT_EN
  input  logic            iABORT,
`endif
  output logic [IABW:0]   oISSUED_CNT
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [IABW-1:0] rd_ptr_q, rd_ptr_d;
  logic [IABW:0]   remaining_q, remaining_d;
  logic [IABW:0]   issued_q, issued_d;
  logic [DBW-1:0]  fifo_q [2];
  logic            head_q, head_d;
  logic [1:0]      occ_q, occ_d;
  logic            inflight_q, inflight_d;
  logic            guard_q, guard_d;

  logic            pop, push, rd, abort, last_pop, wr_idx;
  logic [2:0]      pending;

`ifdef GPPCU_DISPATCH_ABORT_EN
  assign abort = iABORT & (state_q == StRun);
`else
  assign abort = 1'b0;
`endif

  // Handshake, prefetch request and FIFO bookkeeping
  always_comb begin
    oINSTR_VALID = (occ_q != 2'd0);
    pop          = oINSTR_VALID & iINSTR_READY;
    // Data returning during an abort cycle is dropped; nothing is requested while aborting.
    push         = inflight_q & ~abort;
    pending      = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd           = (state_q == StRun) & (remaining_q != '0) & (pending < 3'd2) & ~abort;
    last_pop     = pop & (remaining_q == '0) & ~inflight_q & (occ_q == 2'd1);
    wr_idx       = head_q ^ occ_q[0];
  end

  assign oIMEM_RD    = rd;
  assign oIMEM_ADDR  = rd_ptr_q;
  assign oINSTR      = fifo_q[head_q];
  assign oISSUED_CNT = issued_q;
  assign oBUSY       = (state_q != StIdle);
  assign oDONE       = (state_q == StDone);

  // Next-state logic for the control FSM and datapath counters
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    issued_d    = issued_q;
    head_d      = head_q;
    occ_d       = occ_q + {1'b0, push} - {1'b0, pop};
    inflight_d  = rd;
    guard_d     = 1'b0;

    if (rd) begin
      rd_ptr_d    = rd_ptr_q + IABW'(1);
      remaining_d = remaining_q - (IABW+1)'(1);
    end
    if (pop) begin
      head_d   = ~head_q;
      issued_d = issued_q + (IABW+1)'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (iSTART) begin
          rd_ptr_d    = iBASE_ADDR;
          remaining_d = iCOUNT;
          issued_d    = '0;
          head_d      = 1'b0;
          occ_d       = 2'd0;
          if (iCOUNT == '0) begin
            state_d = StDrain;
            guard_d = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (abort) begin
          occ_d       = 2'd0;
          remaining_d = '0;
          state_d     = StDrain;
          guard_d     = 1'b1;
        end else if (last_pop) begin
          state_d = StDrain;
          guard_d = 1'b1;
        end
      end
      StDrain: begin
        // The first drain cycle ignores iCORE_IDLING so the last instruction can enter the core.
        if (!guard_q && iCORE_IDLING) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control and counter state registers
  always_ff @(posedge iACLK or negedge inRST) begin
    if (!inRST) begin
      state_q     <= StIdle;
      rd_ptr_q    <= '0;
      remaining_q <= '0;
      issued_q    <= '0;
      head_q      <= 1'b0;
      occ_q       <= 2'd0;
      inflight_q  <= 1'b0;
      guard_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      remaining_q <= remaining_d;
      issued_q    <= issued_d;
      head_q      <= head_d;
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      guard_q     <= guard_d;
    end
  end

  // Prefetch FIFO storage
  always_ff @(posedge iACLK or negedge inRST) begin
    if (!inRST) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else if (push) begin
      fifo_q[wr_idx] <= iIMEM_RDATA;
    end
  end

  // A push into a full FIFO without a pop would lose an instruction.
  fifo_no_overflow: assert property (@(posedge iACLK) disable iff (!inRST)
    !(push && !pop && (occ_q == 2'd2)));

endmodule

// File: tb/tb_gppcu_instr_dispatcher.sv
// Self-checking bench for gppcu_instr_dispatcher. A RAM model feeds the DUT; expected read
// addresses and instruction words come from the bench's own copy of RAM contents.
module tb_gppcu_instr_dispatcher;
  localparam int DBW   = 32;
  localparam int IABW  = 10;
  localparam int DEPTH = 1 << IABW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [IABW-1:0] base_addr = '0;
  logic [IABW:0]   count = '0;
  logic            busy, done, imem_rd, instr_valid;
  logic [IABW-1:0] imem_addr;
  logic [DBW-1:0]  imem_rdata = '0;
  logic [DBW-1:0]  instr;
  logic            instr_ready = 1'b0;
  logic            core_idling = 1'b0;
  logic [IABW:0]   issued_cnt;
`ifdef GPPCU_DISPATCH_ABORT_EN
  logic            abort = 1'b0;
`endif

  logic [DBW-1:0]  mem [DEPTH];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Synchronous instruction RAM: data one cycle after the read strobe
  always @(posedge clk) if (imem_rd) imem_rdata <= mem[imem_addr];

  gppcu_instr_dispatcher #(.DBW(DBW), .IABW(IABW)) dut (
    .iACLK        (clk),
    .inRST        (rst_n),
    .iSTART       (start),
    .iBASE_ADDR   (base_addr),
    .iCOUNT       (count),
    .oBUSY        (busy),
    .oDONE        (done),
    .oIMEM_ADDR   (imem_addr),
    .oIMEM_RD     (imem_rd),
    .iIMEM_RDATA  (imem_rdata),
    .oINSTR       (instr),
    .oINSTR_VALID (instr_valid),
    .iINSTR_READY (instr_ready),
    .iCORE_IDLING (core_idling),
`ifdef GPPCU_DISPATCH_ABORT_EN
    .iABORT       (abort),
`endif
    .oISSUED_CNT  (issued_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_rd"}, 64'(imem_rd), 64'(0));
    check({tag, "_valid"}, 64'(instr_valid), 64'(0));
    check({tag, "_addr"}, 64'(imem_addr), 64'(0));
    check({tag, "_instr"}, 64'(instr), 64'(0));
    check({tag, "_issued"}, 64'(issued_cnt), 64'(0));
  endtask

  // One start..done transaction. rmode: 0 ready high, 1 stall 5 cycles then toggle, 2 random.
  // stop_kind: 0 none, 1 reset after stop_after handshakes, 2 abort after stop_after handshakes.
  task automatic run_block(input logic [IABW-1:0] b, input int cnt, input int rmode,
                           input int stop_after, input int stop_kind, input int idle_delay);
    logic [DBW-1:0]  exp_words[$];
    logic [IABW-1:0] exp_addrs[$];
    int nreads = 0, npops = 0, cyc = 0, first_valid = -1, first_pop = -1, last_pop = -1;
    int finish = -1, done_cyc = -1, abort_cyc = -1, max_out = 0, late_reads = 0, exp_n, exp_done;
    bit finished = 0, stalled = 0, busy_ok = 1;
    logic [DBW-1:0] stall_word = '0;

    for (int i = 0; i < cnt; i++) begin
      exp_addrs.push_back(IABW'((int'(b) + i) % DEPTH));
      exp_words.push_back(mem[(int'(b) + i) % DEPTH]);
    end
    if (cnt == 0) finished = 1;

    @(posedge clk); #1;
    start = 1'b1; base_addr = b; count = (IABW+1)'(cnt);
    instr_ready = 1'b0; core_idling = 1'b0;
    @(posedge clk); #1;

    while (done_cyc < 0 && cyc < 400) begin
      // Drive phase: a second start with other operands must be ignored outside idle.
      start = (cyc == 1);
      base_addr = IABW'($urandom);
      count = (IABW+1)'($urandom_range(1, 20));
      core_idling = finished && (cyc >= finish + 1 + idle_delay);
      case (rmode)
        0:       instr_ready = 1'b1;
        1:       instr_ready = (first_valid >= 0 && cyc >= first_valid + 5) ? cyc[0] : 1'b0;
        default: instr_ready = 1'($urandom_range(0, 1));
      endcase
`ifdef GPPCU_DISPATCH_ABORT_EN
      abort = 1'b0;
      if (stop_kind == 2 && abort_cyc < 0 && npops == stop_after) begin
        abort = 1'b1; instr_ready = 1'b0; abort_cyc = cyc;
        finished = 1; finish = cyc;
      end
`endif
      if (stop_kind == 1 && npops == stop_after) begin
        rst_n = 1'b0; start = 1'b0; instr_ready = 1'b0;
        #1 check_all_zero("midrun_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end

      @(negedge clk);
      if (!busy) busy_ok = 0;
      if (imem_rd) begin
        if (abort_cyc >= 0 && cyc > abort_cyc) late_reads++;
        if (nreads < cnt) check("rd_addr", 64'(imem_addr), 64'(exp_addrs[nreads]));
        nreads++;
      end
      if (stalled && abort_cyc < 0) begin
        check("stall_valid", 64'(instr_valid), 64'(1));
        check("stall_word", 64'(instr), 64'(stall_word));
      end
      if (abort_cyc >= 0 && cyc == abort_cyc + 1)
        check("abort_valid_drop", 64'(instr_valid), 64'(0));
      if (instr_valid && first_valid < 0) first_valid = cyc;
      if (instr_valid && instr_ready) begin
        if (npops < cnt) check("instr", 64'(instr), 64'(exp_words[npops]));
        npops++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        if (npops == cnt) begin finished = 1; finish = cyc; end
      end
      stalled = instr_valid && !instr_ready;
      stall_word = instr;
      if (nreads - npops > max_out) max_out = nreads - npops;
      if (done) done_cyc = cyc;
      @(posedge clk); #1;
      cyc++;
    end
`ifdef GPPCU_DISPATCH_ABORT_EN
    abort = 1'b0;
`endif
    start = 1'b0;

    exp_n = (stop_kind == 2) ? stop_after : cnt;
    if (done_cyc < 0) begin
      check("done_timeout", 64'(0), 64'(1));
    end else begin
      exp_done = ((finish + 2 > finish + 1 + idle_delay) ? finish + 2 : finish + 1 + idle_delay) + 1;
      check("done_cycle", 64'(done_cyc), 64'(exp_done));
    end
    check("busy_during_op", 64'(busy_ok), 64'(1));
    check("handshakes", 64'(npops), 64'(exp_n));
    check("max_outstanding", 64'(max_out <= 2), 64'(1));
    if (stop_kind == 2) check("reads_after_abort", 64'(late_reads), 64'(0));
    else check("read_count", 64'(nreads), 64'(cnt));
    if (cnt == 0) check("no_valid_on_zero", 64'(first_valid), 64'(-1));
    else check("first_valid_cycle", 64'(first_valid), 64'(2));
    if (rmode == 0 && stop_kind == 0 && cnt > 0)
      check("throughput", 64'(last_pop - first_pop), 64'(cnt - 1));
    @(negedge clk);
    check("issued_cnt", 64'(issued_cnt), 64'(exp_n));
    check("done_one_cycle", 64'(done), 64'(0));
    check("idle_after_done", 64'(busy), 64'(0));
    core_idling = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) mem[a] = 32'(a + 'h100);
    #2 check_all_zero("reset");
    #10 rst_n = 1'b1;

    run_block(10'h010, 4, 0, 0, 0, 0);   // basic burst, ready high
    run_block(10'h020, 6, 1, 0, 0, 1);   // stall then toggle
    run_block(10'h000, 0, 0, 0, 0, 0);   // zero count, idle already high in guard cycle
    run_block(10'h3FE, 4, 0, 0, 0, 2);   // address wrap
    run_block(10'h100, 6, 0, 2, 1, 0);   // reset mid-run after 2 issues
    run_block(10'h200, 3, 0, 0, 0, 1);   // clean restart after reset
`ifdef GPPCU_DISPATCH_ABORT_EN
    run_block(10'h300, 8, 0, 3, 2, 1);   // abort after 3 handshakes
`endif

    for (int a = 0; a < DEPTH; a++) mem[a] = $urandom;
    for (int r = 0; r < 12; r++)
      run_block(IABW'($urandom), int'($urandom_range(0, 12)), int'($urandom_range(0, 2)),
                0, 0, int'($urandom_range(0, 3)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
